// File: rtl/mirfak_hazard_ctrl_if.sv
// Signal bundle between the ID stage / pipeline registers and the hazard controller.
// The controller takes the slave side; whoever drives the ID-stage fields takes the master side.
interface mirfak_hazard_ctrl_if;
    logic       id_valid_i;
    logic [4:0] id_rs1_i;
    logic [4:0] id_rs2_i;
    logic       id_use_rs1_i;
    logic       id_use_rs2_i;
    logic [4:0] id_rd_i;
    logic       id_wen_i;
    logic       id_is_load_i;
    logic       take_branch_i;
    logic       ex_busy_i;
    logic       trap_i;
    logic [1:0] id_fwd_a_sel_o;
    logic [1:0] id_fwd_b_sel_o;
    logic       pc_enable_o;
    logic       ifid_enable_o;
    logic       ifid_clear_o;
    logic       idex_enable_o;
    logic       idex_clear_o;
    logic       exwb_enable_o;
    logic       exwb_clear_o;

    modport master (
        output id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
               id_rd_i, id_wen_i, id_is_load_i, take_branch_i, ex_busy_i, trap_i,
        input  id_fwd_a_sel_o, id_fwd_b_sel_o, pc_enable_o, ifid_enable_o,
               ifid_clear_o, idex_enable_o, idex_clear_o, exwb_enable_o, exwb_clear_o
    );

    modport slave (
        input  id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
               id_rd_i, id_wen_i, id_is_load_i, take_branch_i, ex_busy_i, trap_i,
        output id_fwd_a_sel_o, id_fwd_b_sel_o, pc_enable_o, ifid_enable_o,
               ifid_clear_o, idex_enable_o, idex_clear_o, exwb_enable_o, exwb_clear_o
    );
endinterface

// File: rtl/mirfak_hazard_ctrl.sv
// ID-stage hazard controller: forwarding selects, load-use / multi-cycle stalls,
// branch kill and a counted trap flush, plus every IFID/IDEX/EXWB enable and clear.
module mirfak_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input logic                 clk_i,
    input logic                 rst_i,
    mirfak_hazard_ctrl_if.slave hz
);

    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       use_rs,
        input logic       ex_fwd_ok,
        input logic [4:0] ex_rd,
        input logic       wb_writer,
        input logic [4:0] wb_rd
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (use_rs && rs != 5'd0) begin
            if (ex_fwd_ok && ex_rd == rs)
                sel = 2'b01;
            else if (wb_writer && wb_rd == rs)
                sel = 2'b10;
        end
        return sel;
    endfunction

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       rst_hold;

    logic       ex_vld_p1, wb_vld_p2;
    logic [4:0] ex_rd_p1, wb_rd_p2;
    logic       ex_wen_p1, wb_wen_p2;
    logic       ex_ld_p1;

    logic       ex_writer, wb_writer, load_use;
    logic       pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exwb_en, exwb_clr;
    logic [1:0] fwd_a, fwd_b;

    // Outputs stay forced for one full cycle after reset release so the first
    // fetch sees cleared pipeline registers regardless of where rst_i dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rst_hold <= 1'b1;
        else       rst_hold <= 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RUN: begin
                if (hz.trap_i) begin
                    state_nxt = FLUSH;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            FLUSH: begin
                if (hz.trap_i)
                    cnt_nxt = CNT_LOAD;
                else if (cnt == 4'd0)
                    state_nxt = RUN;
                else
                    cnt_nxt = cnt - 4'd1;
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    assign ex_writer = ex_vld_p1 && ex_wen_p1 && (ex_rd_p1 != 5'd0);
    assign wb_writer = wb_vld_p2 && wb_wen_p2 && (wb_rd_p2 != 5'd0);

    assign load_use = hz.id_valid_i && ex_writer && ex_ld_p1 &&
                      ((hz.id_use_rs1_i && hz.id_rs1_i == ex_rd_p1) ||
                       (hz.id_use_rs2_i && hz.id_rs2_i == ex_rd_p1));

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (!(rst_i || rst_hold)) begin
            // A load in EX has no data yet; it must fall through to WB (or stall).
            fwd_a = fwd_sel(hz.id_rs1_i, hz.id_use_rs1_i, ex_writer && !ex_ld_p1,
                            ex_rd_p1, wb_writer, wb_rd_p2);
            fwd_b = fwd_sel(hz.id_rs2_i, hz.id_use_rs2_i, ex_writer && !ex_ld_p1,
                            ex_rd_p1, wb_writer, wb_rd_p2);
        end
    end

    always_comb begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        ifid_clr = 1'b0;
        idex_en  = 1'b1;
        idex_clr = 1'b0;
        exwb_en  = 1'b1;
        exwb_clr = 1'b0;
        if (rst_i || rst_hold) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exwb_en  = 1'b0;
            ifid_clr = 1'b1;
            idex_clr = 1'b1;
            exwb_clr = 1'b1;
        end else if (state == FLUSH || hz.trap_i) begin
            // PC keeps advancing so the trap vector fetch proceeds during the flush.
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exwb_en  = 1'b0;
            ifid_clr = 1'b1;
            idex_clr = 1'b1;
            exwb_clr = 1'b1;
        end else if (hz.ex_busy_i) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exwb_en  = 1'b0;
            exwb_clr = 1'b1;
        end else if (load_use) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            idex_clr = 1'b1;
        end else if (hz.take_branch_i) begin
            ifid_clr = 1'b1;
        end
    end

    // ---- EX tracking slot (mirrors IDEX) ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            ex_vld_p1 <= 1'b0;
        else if (state == FLUSH || idex_clr)
            ex_vld_p1 <= 1'b0;
        else if (idex_en)
            ex_vld_p1 <= hz.id_valid_i;
    end

    always_ff @(posedge clk_i) begin
        if (idex_en) begin
            ex_rd_p1  <= hz.id_rd_i;
            ex_wen_p1 <= hz.id_wen_i;
            ex_ld_p1  <= hz.id_is_load_i;
        end
    end

    // ---- WB tracking slot (mirrors EXWB) ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            wb_vld_p2 <= 1'b0;
        else if (exwb_clr)
            wb_vld_p2 <= 1'b0;
        else if (exwb_en)
            wb_vld_p2 <= ex_vld_p1;
    end

    always_ff @(posedge clk_i) begin
        if (exwb_en) begin
            wb_rd_p2  <= ex_rd_p1;
            wb_wen_p2 <= ex_wen_p1;
        end
    end

    assign hz.id_fwd_a_sel_o = fwd_a;
    assign hz.id_fwd_b_sel_o = fwd_b;
    assign hz.pc_enable_o    = pc_en;
    assign hz.ifid_enable_o  = ifid_en;
    assign hz.ifid_clear_o   = ifid_clr;
    assign hz.idex_enable_o  = idex_en;
    assign hz.idex_clear_o   = idex_clr;
    assign hz.exwb_enable_o  = exwb_en;
    assign hz.exwb_clear_o   = exwb_clr;

endmodule

// File: tb/tb_mirfak_hazard_ctrl.sv
// Bench for mirfak_hazard_ctrl: directed scenarios plus random traffic against a
// slot/flush-countdown reference model.
module tb_mirfak_hazard_ctrl;

    localparam int FC = 2;

    // {pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exwb_en, exwb_clr}
    localparam logic [6:0] RESETV  = 7'b0010101;
    localparam logic [6:0] FLUSHV  = 7'b1010101;
    localparam logic [6:0] BUSYV   = 7'b0000001;
    localparam logic [6:0] LOADV   = 7'b0000110;
    localparam logic [6:0] BRANCHV = 7'b1111010;
    localparam logic [6:0] DEFV    = 7'b1101010;

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
        logic       wen;
        logic       ld;
    } slot_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mirfak_hazard_ctrl_if hz();

    mirfak_hazard_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .hz    (hz)
    );

    wire [6:0] ctrl = {hz.pc_enable_o, hz.ifid_enable_o, hz.ifid_clear_o,
                       hz.idex_enable_o, hz.idex_clear_o, hz.exwb_enable_o, hz.exwb_clear_o};
    wire [3:0] fwd  = {hz.id_fwd_a_sel_o, hz.id_fwd_b_sel_o};

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    slot_t m_ex, m_wb;
    int    m_flush_left;
    logic  m_hold;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic u1, input logic u2, input logic [4:0] rd,
                            input logic wen, input logic ld);
        hz.id_valid_i   = v;
        hz.id_rs1_i     = rs1;
        hz.id_rs2_i     = rs2;
        hz.id_use_rs1_i = u1;
        hz.id_use_rs2_i = u2;
        hz.id_rd_i      = rd;
        hz.id_wen_i     = wen;
        hz.id_is_load_i = ld;
    endtask

    function automatic logic [1:0] m_fwd(input logic [4:0] rs, input logic use_rs);
        if (m_hold || !use_rs || rs == 5'd0) return 2'b00;
        if (m_ex.vld && m_ex.wen && !m_ex.ld && m_ex.rd == rs) return 2'b01;
        if (m_wb.vld && m_wb.wen && m_wb.rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [6:0] m_ctrl();
        logic lu;
        lu = hz.id_valid_i && m_ex.vld && m_ex.wen && m_ex.ld && m_ex.rd != 5'd0 &&
             ((hz.id_use_rs1_i && hz.id_rs1_i == m_ex.rd) ||
              (hz.id_use_rs2_i && hz.id_rs2_i == m_ex.rd));
        if (m_hold) return RESETV;
        if (m_flush_left > 0 || hz.trap_i) return FLUSHV;
        if (hz.ex_busy_i) return BUSYV;
        if (lu) return LOADV;
        if (hz.take_branch_i) return BRANCHV;
        return DEFV;
    endfunction

    task automatic model_advance();
        logic [6:0] c;
        slot_t      ex_old;
        c      = m_ctrl();
        ex_old = m_ex;
        if (c[0])      m_wb.vld = 1'b0;
        else if (c[1]) m_wb = ex_old;
        if (m_flush_left > 0 || c[2]) m_ex.vld = 1'b0;
        else if (c[3]) m_ex = '{vld: hz.id_valid_i, rd: hz.id_rd_i, wen: hz.id_wen_i, ld: hz.id_is_load_i};
        if (hz.trap_i)             m_flush_left = FC;
        else if (m_flush_left > 0) m_flush_left--;
        m_hold = 1'b0;
    endtask

    task automatic test_reset();
        drive_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if (ctrl !== RESETV) begin n_fail++; $display("FAIL rst_ctrl: got %b want %b", ctrl, RESETV); end
        n_checks++;
        if (fwd !== 4'b0000) begin n_fail++; $display("FAIL rst_fwd: got %b want 0000", fwd); end
        @(posedge clk);
        #1 rst = 1'b0;
        drive_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if (ctrl !== RESETV) begin n_fail++; $display("FAIL rst_hold: got %b want %b", ctrl, RESETV); end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (ctrl !== DEFV) begin n_fail++; $display("FAIL rst_after: got %b want %b", ctrl, DEFV); end
        next_cycle();
    endtask

    task automatic test_forwarding();
        drive_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
        next_cycle();
        drive_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if (fwd !== 4'b0101) begin n_fail++; $display("FAIL ex_fwd: got %b want 0101", fwd); end
        n_checks++;
        if (ctrl !== DEFV) begin n_fail++; $display("FAIL ex_fwd_nostall: got %b want %b", ctrl, DEFV); end
        next_cycle();
        drive_id(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if (fwd !== 4'b1000) begin n_fail++; $display("FAIL wb_fwd: got %b want 1000", fwd); end
        next_cycle();
        drive_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        next_cycle();
        drive_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if (fwd !== 4'b0000) begin n_fail++; $display("FAIL x0_fwd: got %b want 0000", fwd); end
        next_cycle();
    endtask

    task automatic test_load_use();
        drive_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1);
        next_cycle();
        drive_id(1'b1, 5'd3, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if (ctrl !== LOADV) begin n_fail++; $display("FAIL lu_stall: got %b want %b", ctrl, LOADV); end
        n_checks++;
        if (fwd !== 4'b0000) begin n_fail++; $display("FAIL lu_fwd_stall: got %b want 0000", fwd); end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (ctrl !== DEFV) begin n_fail++; $display("FAIL lu_resume: got %b want %b", ctrl, DEFV); end
        n_checks++;
        if (fwd !== 4'b0010) begin n_fail++; $display("FAIL lu_fwd_wb: got %b want 0010", fwd); end
        next_cycle();
    endtask

    task automatic test_branch();
        drive_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        hz.take_branch_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ctrl !== BRANCHV) begin n_fail++; $display("FAIL br_kill: got %b want %b", ctrl, BRANCHV); end
        next_cycle();
        hz.take_branch_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ctrl !== DEFV) begin n_fail++; $display("FAIL br_one_cycle: got %b want %b", ctrl, DEFV); end
        next_cycle();
    endtask

    task automatic test_busy();
        logic [1:0] exp_a;
        drive_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
        next_cycle();
        drive_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        next_cycle();
        drive_id(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        hz.ex_busy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_a = (i == 0) ? 2'b10 : 2'b00;
            @(negedge clk);
            n_checks++;
            if (ctrl !== BUSYV) begin n_fail++; $display("FAIL busy_ctrl[%0d]: got %b want %b", i, ctrl, BUSYV); end
            n_checks++;
            if (hz.id_fwd_a_sel_o !== exp_a) begin n_fail++; $display("FAIL busy_wb_fwd[%0d]: got %b want %b", i, hz.id_fwd_a_sel_o, exp_a); end
            next_cycle();
        end
        hz.ex_busy_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ctrl !== DEFV) begin n_fail++; $display("FAIL busy_done: got %b want %b", ctrl, DEFV); end
        n_checks++;
        if (hz.id_fwd_a_sel_o !== 2'b00) begin n_fail++; $display("FAIL busy_wb_gone: got %b want 00", hz.id_fwd_a_sel_o); end
        next_cycle();
    endtask

    task automatic test_trap();
        logic [6:0] exp_c;
        drive_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0);
        next_cycle();
        drive_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0);
        next_cycle();
        drive_id(1'b1, 5'd8, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        hz.trap_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (fwd !== 4'b0110) begin n_fail++; $display("FAIL trap_pre_fwd: got %b want 0110", fwd); end
        n_checks++;
        if (ctrl !== FLUSHV) begin n_fail++; $display("FAIL trap_T: got %b want %b", ctrl, FLUSHV); end
        next_cycle();
        hz.trap_i = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            exp_c = (k <= FC) ? FLUSHV : DEFV;
            @(negedge clk);
            n_checks++;
            if (ctrl !== exp_c) begin n_fail++; $display("FAIL trap_T+%0d: got %b want %b", k, ctrl, exp_c); end
            if (k == 1) begin
                n_checks++;
                if (fwd !== 4'b0000) begin n_fail++; $display("FAIL trap_slots: got %b want 0000", fwd); end
            end
            next_cycle();
        end
        for (int k = 0; k <= 4; k++) begin
            hz.trap_i = (k < 2);
            exp_c = (k < 4) ? FLUSHV : DEFV;
            @(negedge clk);
            n_checks++;
            if (ctrl !== exp_c) begin n_fail++; $display("FAIL trap2_T+%0d: got %b want %b", k, ctrl, exp_c); end
            next_cycle();
        end
        hz.trap_i = 1'b0;
    endtask

    task automatic test_reset_mid_flush();
        drive_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        hz.trap_i = 1'b1;
        next_cycle();
        hz.trap_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (ctrl !== RESETV) begin n_fail++; $display("FAIL mid_rst_ctrl: got %b want %b", ctrl, RESETV); end
        n_checks++;
        if (fwd !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_fwd: got %b want 0000", fwd); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ctrl !== RESETV) begin n_fail++; $display("FAIL mid_rst_hold: got %b want %b", ctrl, RESETV); end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (ctrl !== DEFV) begin n_fail++; $display("FAIL mid_rst_run: got %b want %b", ctrl, DEFV); end
        next_cycle();
    endtask

    task automatic test_random();
        logic [10:0] exp_v, got_v;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        m_ex = '0;
        m_wb = '0;
        m_flush_left = 0;
        m_hold = 1'b1;
        for (int i = 0; i < 400; i++) begin
            drive_id($urandom_range(0, 9) < 8, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                     1'($urandom), $urandom_range(0, 9) < 3);
            hz.take_branch_i = $urandom_range(0, 4) == 0;
            hz.ex_busy_i     = $urandom_range(0, 6) == 0;
            hz.trap_i        = $urandom_range(0, 19) == 0;
            @(negedge clk);
            exp_v = {m_fwd(hz.id_rs1_i, hz.id_use_rs1_i), m_fwd(hz.id_rs2_i, hz.id_use_rs2_i), m_ctrl()};
            got_v = {fwd, ctrl};
            n_checks++;
            if (got_v !== exp_v) begin n_fail++; $display("FAIL rand[%0d] fwd_ctrl: got %b want %b", i, got_v, exp_v); end
            model_advance();
            next_cycle();
        end
        hz.take_branch_i = 1'b0;
        hz.ex_busy_i     = 1'b0;
        hz.trap_i        = 1'b0;
        drive_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        hz.take_branch_i = 1'b0;
        hz.ex_busy_i     = 1'b0;
        hz.trap_i        = 1'b0;
        drive_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_busy();
        test_trap();
        test_reset_mid_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
